pipeline_control_unit: RTL

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

---
 rtl/pipeline_control_unit_pkg.sv | 14 +
 rtl/pipeline_control_unit_sat_counter.sv | 35 +++
 rtl/pipeline_control_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit: FSM encoding and
// default parameter values.
package pipeline_control_unit_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } pcu_state_e;

   localparam int unsigned PCU_MEM_TIMEOUT_DEF = 16;
   localparam int unsigned PCU_CNT_W_DEF       = 16;

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: advance on inc unless already at the ceiling.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline stage controller: write enables, flushes and PC select from
// hazard, branch and data-memory status, with memory-timeout HALT.
module pipeline_control_unit
   import pipeline_control_unit_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = PCU_MEM_TIMEOUT_DEF,
   parameter int unsigned CNT_W       = PCU_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_req,
   input  logic             branch_taken_ex,
   input  logic             dmem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_we,
   output logic             id_ex_flush,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             pc_sel_target,
   output logic             halted,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned      TMO_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   pcu_state_e       state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             run_ctl;
   logic             stall_inc;

   // Next state, timeout tracking and the "behave as RUN" qualifier.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      run_ctl = 1'b0;
      case (state_q)
         ST_RUN, ST_MEM_WAIT: begin
            if (dmem_busy) begin
               tmo_d = tmo_q + TMO_W'(1);
               if (tmo_q == TMO_LAST) begin
                  state_d = ST_HALT;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_MEM_WAIT;
               end
            end else begin
               // MEM_WAIT exit cycle acts as RUN so no request is lost.
               tmo_d   = {TMO_W{1'b0}};
               state_d = ST_RUN;
               run_ctl = 1'b1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
            tmo_d   = {TMO_W{1'b0}};
         end
      endcase
   end

   // Control outputs; everything is forced low while reset is asserted.
   always_comb begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_we      = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_we     = 1'b0;
      pc_sel_target = 1'b0;
      if (rst_n && run_ctl) begin
         pc_we     = 1'b1;
         if_id_we  = 1'b1;
         id_ex_we  = 1'b1;
         ex_mem_we = 1'b1;
         mem_wb_we = 1'b1;
         if (branch_taken_ex) begin
            pc_sel_target = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
         end else if (stall_req) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
         end else begin
            pc_sel_target = 1'b0;
         end
      end else begin
         pc_we = 1'b0;
      end
   end

   // FSM, timeout counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         tmo_q   <= {TMO_W{1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign halted          = rst_n & (state_q == ST_HALT);
   assign mem_timeout_err = err_q;
   assign stall_inc       = rst_n & ~pc_we;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pc_sel_target),
      .count (flush_cnt)
   );

endmodule
